par_cnt_scaled_add: RTL

//  Parametrised N-input parallel counter with scaled-addition accumulator for unary bitstreams.

---
 rtl/par_cnt_scaled_add_pkg.sv | 33 +++
 rtl/par_cnt_scaled_add_popcnt_tree.sv | 100 ++++++++++
 rtl/par_cnt_scaled_add.sv | 100 ++++++++++
 3 files changed

// File: rtl/par_cnt_scaled_add_pkg.sv
// Shared helpers for the unary scaled-adder datapath: width functions and an
// elaboration-time parameter guard used by every block in the slice.
`ifndef USADD_PKG_SV
`define USADD_PKG_SV

// Expands to a named generate block that stops elaboration when cond is false.
`define USADD_PCHECK(lbl, cond, msg) \
  if (!(cond)) begin : lbl \
    $error(msg); \
  end

package usadd_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Bits needed to hold a popcount of num_in inputs (0..num_in).
  function automatic int cnt_w(input int num_in);
    return clog2(num_in + 1);
  endfunction

  // Bits needed for acc + cnt, whose maximum is scale - 1 + num_in.
  function automatic int acc_w(input int scale, input int num_in);
    return clog2(scale + num_in);
  endfunction

endpackage

`endif

// File: rtl/par_cnt_scaled_add_popcnt_tree.sv
// Generalised 7:3 counter: a 3:2 full-adder tree reduces NUM_IN bits to carry-save
// form, an optional register splits the tree, and one adder resolves the count.
module popcnt_tree
  import usadd_pkg::*;
#(
  parameter  int NUM_IN    = 7,
  parameter  int PIPE_TREE = 0,
  localparam int CNT_W     = cnt_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              i_vld,
  input  logic [NUM_IN-1:0] i_bits,
  output logic              o_vld,
  output logic [CNT_W-1:0]  o_cnt
);

  localparam int COL_H = NUM_IN + 1;

  // Column-wise full-adder reduction until every weight holds at most two bits.
  // Carries out of the top column are dropped: the count always fits in CNT_W.
  function automatic void csa_reduce(input  logic [NUM_IN-1:0] bits,
                                     output logic [CNT_W-1:0]  row0,
                                     output logic [CNT_W-1:0]  row1);
    logic m [CNT_W][COL_H];
    int   h [CNT_W];
    logic a, b, c;
    for (int w = 0; w < CNT_W; w++) begin
      h[w] = 0;
      for (int k = 0; k < COL_H; k++) m[w][k] = 1'b0;
    end
    for (int k = 0; k < NUM_IN; k++) m[0][k] = bits[k];
    h[0] = NUM_IN;
    for (int w = 0; w < CNT_W; w++) begin
      for (int f = 0; f < NUM_IN; f++) begin
        if (h[w] > 2) begin
          a = m[w][h[w]-1];
          b = m[w][h[w]-2];
          c = m[w][h[w]-3];
          h[w] = h[w] - 2;
          m[w][h[w]-1] = a ^ b ^ c;
          if (w + 1 < CNT_W) begin
            m[w+1][h[w+1]] = (a & b) | (c & (a ^ b));
            h[w+1] = h[w+1] + 1;
          end
        end
      end
      row0[w] = (h[w] > 0) ? m[w][0] : 1'b0;
      row1[w] = (h[w] > 1) ? m[w][1] : 1'b0;
    end
  endfunction

  logic [CNT_W-1:0] w_row0, w_row1;
  logic [CNT_W-1:0] w_fin0, w_fin1;
  logic             w_vld;

  // NOTE: every variable assigned in always_comb is written on all paths, so no latch is inferred.
  always_comb begin
    w_row0 = '0;
    w_row1 = '0;
    csa_reduce(i_bits, w_row0, w_row1);
  end

  if (PIPE_TREE != 0) begin : g_pipe
    logic [CNT_W-1:0] r_row0, r_row1;
    logic             r_vld;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_row0 <= '0;
        r_row1 <= '0;
        r_vld  <= 1'b0;
      end else if (clr) begin
        r_vld  <= 1'b0;
      end else begin
        r_vld <= i_vld;
        if (i_vld) begin
          r_row0 <= w_row0;
          r_row1 <= w_row1;
        end
      end
    end

    assign w_fin0 = r_row0;
    assign w_fin1 = r_row1;
    assign w_vld  = r_vld;
  end else begin : g_comb
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, clr};
    assign w_fin0   = w_row0;
    assign w_fin1   = w_row1;
    assign w_vld    = i_vld;
  end

  assign o_cnt = w_fin0 + w_fin1;
  assign o_vld = w_vld;

endmodule

// File: rtl/par_cnt_scaled_add.sv
// N-input parallel counter feeding a modulo-SCALE accumulator; one output bit per
// valid count, set on every wrap, so out rate = sum of input rates / SCALE.
module par_cnt_scaled_add
  import usadd_pkg::*;
#(
  parameter  int NUM_IN    = 7,
  parameter  int SCALE     = 7,
  parameter  int ACC_INIT  = 0,
  parameter  int PIPE_TREE = 0,
  localparam int CNT_W     = cnt_w(NUM_IN),
  localparam int ACC_W     = acc_w(SCALE, NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [NUM_IN-1:0] in,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              cnt_vld,
  output logic              out,
  output logic              out_vld,
  output logic [ACC_W-1:0]  acc
);

  `USADD_PCHECK(g_chk_num_in,   NUM_IN >= 2,                "par_cnt_scaled_add: NUM_IN must be >= 2")
  `USADD_PCHECK(g_chk_scale_lo, SCALE >= NUM_IN,            "par_cnt_scaled_add: SCALE must be >= NUM_IN")
  `USADD_PCHECK(g_chk_scale_hi, SCALE < 65536,              "par_cnt_scaled_add: SCALE must be < 2**16")
  `USADD_PCHECK(g_chk_init,     ACC_INIT >= 0 && ACC_INIT < SCALE, "par_cnt_scaled_add: ACC_INIT must be < SCALE")

  localparam logic [ACC_W-1:0] SCALE_V = ACC_W'(SCALE);
  localparam logic [ACC_W-1:0] INIT_V  = ACC_W'(ACC_INIT);

  logic             w_tree_vld;
  logic [CNT_W-1:0] w_tree_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_vld;
  logic [ACC_W-1:0] r_acc;
  logic             r_out, r_out_vld;
  logic [ACC_W-1:0] w_sum, w_acc_next;
  logic             w_wrap;

  // clr beats en, so a sample presented with clr never enters the tree.
  popcnt_tree #(
    .NUM_IN    (NUM_IN),
    .PIPE_TREE (PIPE_TREE)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .i_vld  (en & ~clr),
    .i_bits (in),
    .o_vld  (w_tree_vld),
    .o_cnt  (w_tree_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_cnt_vld <= 1'b0;
    end else if (clr) begin
      r_cnt_vld <= 1'b0;
    end else begin
      r_cnt_vld <= w_tree_vld;
      if (w_tree_vld) r_cnt <= w_tree_cnt;
    end
  end

  // acc < SCALE and cnt <= SCALE keep the sum below 2*SCALE: one subtraction wraps it.
  always_comb begin
    w_sum      = r_acc + ACC_W'(r_cnt);
    w_wrap     = (w_sum >= SCALE_V);
    w_acc_next = w_wrap ? (w_sum - SCALE_V) : w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= INIT_V;
      r_out     <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (clr) begin
      r_acc     <= INIT_V;
      r_out     <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (r_cnt_vld) begin
      r_acc     <= w_acc_next;
      r_out     <= w_wrap;
      r_out_vld <= 1'b1;
    end else begin
      r_out     <= 1'b0;
      r_out_vld <= 1'b0;
    end
  end

  assign cnt_out = r_cnt;
  assign cnt_vld = r_cnt_vld;
  assign out     = r_out;
  assign out_vld = r_out_vld;
  assign acc     = r_acc;

endmodule
